// File: rtl/tmu2_pkg.sv
// Shared constants for the TMU2 texture-addressing wrap stage.
// This package holds the wrap-mode encoding and the default coordinate widths.
package tmu2_pkg;

    typedef enum logic [1:0] {
        WRAP_REPEAT = 2'b00,
        WRAP_CLAMP  = 2'b01,
        WRAP_MIRROR = 2'b10,
        WRAP_RSVD   = 2'b11
    } wrap_mode_e;

    localparam int DEF_DW = 12;
    localparam int DEF_TW = 18;

endpackage

// File: rtl/tmu2_wrap_if.sv
// Pipeline bus of the wrap stage: upstream sample/handshake and downstream result/handshake.
// The slave modport is the wrap stage; the master modport is the surrounding pipeline.
interface tmu2_wrap_if
    import tmu2_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int TW = DEF_TW
);

    logic                 pipe_stb_i;
    logic                 pipe_ack_o;
    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [TW-1:0] tx;
    logic signed [TW-1:0] ty;
    logic        [TW-1:0] tex_hmask;
    logic        [TW-1:0] tex_vmask;
    logic        [1:0]    hmode;
    logic        [1:0]    vmode;

    logic                 pipe_stb_o;
    logic                 pipe_ack_i;
    logic signed [DW-1:0] dx_f;
    logic signed [DW-1:0] dy_f;
    logic        [TW-1:0] tx_m;
    logic        [TW-1:0] ty_m;
    logic                 oor_x;
    logic                 oor_y;

    modport slave (
        input  pipe_stb_i, dx, dy, tx, ty, tex_hmask, tex_vmask, hmode, vmode, pipe_ack_i,
        output pipe_ack_o, pipe_stb_o, dx_f, dy_f, tx_m, ty_m, oor_x, oor_y
    );

    modport master (
        output pipe_stb_i, dx, dy, tx, ty, tex_hmask, tex_vmask, hmode, vmode, pipe_ack_i,
        input  pipe_ack_o, pipe_stb_o, dx_f, dy_f, tx_m, ty_m, oor_x, oor_y
    );

endinterface

// File: rtl/tmu2_wrap_axis.sv
// One texel axis of the wrap stage: classifies the coordinate against the mask in stage 1
// and produces the wrapped coordinate plus out-of-range flag in stage 2.
module tmu2_wrap_axis
    import tmu2_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [TW-1:0] i_c,
    input  logic        [TW-1:0] i_m,
    input  logic        [1:0]    i_mode,
    input  logic                 i_en_p1,
    input  logic                 i_en_p2,
    output logic        [TW-1:0] o_res,
    output logic                 o_oor,
    output logic                 o_clamp_evt
);

    logic [TW-1:0] w_c;
    logic          w_neg;
    logic          w_over;
    logic          w_per;

    logic [TW-1:0] r_c_p1;
    logic [TW-1:0] r_m_p1;
    logic [1:0]    r_mode_p1;
    logic          r_neg_p1;
    logic          r_over_p1;
    logic          r_per_p1;

    logic [TW-1:0] r_res_p2;
    logic          r_oor_p2;

    // Mirror relies on two's complement: the period bit of a negative coordinate
    // already has the right parity, so -1 reflects to 0 without special casing.
    function automatic logic [TW-1:0] wrap_result(
        input logic [TW-1:0] c,
        input logic [TW-1:0] m,
        input logic [1:0]    mode,
        input logic          neg,
        input logic          over,
        input logic          per
    );
        logic [TW-1:0] res;
        case (mode)
            WRAP_CLAMP:  res = neg ? '0 : (over ? m : c);
            WRAP_MIRROR: res = per ? (~c & m) : (c & m);
            default:     res = c & m;
        endcase
        return res;
    endfunction

    assign w_c    = $unsigned(i_c);
    assign w_neg  = w_c[TW-1];
    assign w_over = ~w_neg & (|(w_c & ~i_m));
    assign w_per  = |(w_c & (i_m + TW'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_p1    <= '0;
            r_m_p1    <= '0;
            r_mode_p1 <= '0;
            r_neg_p1  <= 1'b0;
            r_over_p1 <= 1'b0;
            r_per_p1  <= 1'b0;
            r_res_p2  <= '0;
            r_oor_p2  <= 1'b0;
        end else begin
            // stage 1: capture coordinate, mask, mode and classification
            if (i_en_p1) begin
                r_c_p1    <= w_c;
                r_m_p1    <= i_m;
                r_mode_p1 <= i_mode;
                r_neg_p1  <= w_neg;
                r_over_p1 <= w_over;
                r_per_p1  <= w_per;
            end
            // stage 2: wrapped coordinate and out-of-range flag
            if (i_en_p2) begin
                r_res_p2 <= wrap_result(r_c_p1, r_m_p1, r_mode_p1, r_neg_p1, r_over_p1, r_per_p1);
                r_oor_p2 <= r_neg_p1 | r_over_p1;
            end
        end
    end

    assign o_res       = r_res_p2;
    assign o_oor       = r_oor_p2;
    assign o_clamp_evt = (r_mode_p1 == WRAP_CLAMP) & (r_neg_p1 | r_over_p1);

endmodule

// File: rtl/tmu2_wrap.sv
// TMU2 texture-addressing stage: two-stage elastic pipeline applying per-axis
// repeat/clamp/mirror wrapping, with a saturating clamp-event counter.
module tmu2_wrap
    import tmu2_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int TW = DEF_TW,
    parameter int CW = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    tmu2_wrap_if.slave    bus,
    input  logic          clr_count,
    output logic          busy,
    output logic [CW-1:0] clamp_count
);

    logic                 r_vld_p1;
    logic                 r_vld_p2;
    logic signed [DW-1:0] r_dx_p1;
    logic signed [DW-1:0] r_dy_p1;
    logic signed [DW-1:0] r_dx_p2;
    logic signed [DW-1:0] r_dy_p2;
    logic        [CW-1:0] r_cnt;

    logic w_ack_p1;
    logic w_ack_p2;
    logic w_en_p1;
    logic w_en_p2;
    logic w_clamp_x;
    logic w_clamp_y;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // A stage can accept when it is empty or its content leaves this cycle.
    assign w_ack_p2 = ~r_vld_p2 | bus.pipe_ack_i;
    assign w_ack_p1 = ~r_vld_p1 | w_ack_p2;
    assign w_en_p1  = bus.pipe_stb_i & w_ack_p1;
    assign w_en_p2  = r_vld_p1 & w_ack_p2;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_dx_p1  <= '0;
            r_dy_p1  <= '0;
            r_dx_p2  <= '0;
            r_dy_p2  <= '0;
            r_cnt    <= '0;
        end else begin
            // stage 1
            if (w_ack_p1) r_vld_p1 <= bus.pipe_stb_i;
            if (w_en_p1) begin
                r_dx_p1 <= bus.dx;
                r_dy_p1 <= bus.dy;
            end
            // stage 2
            if (w_ack_p2) r_vld_p2 <= r_vld_p1;
            if (w_en_p2) begin
                r_dx_p2 <= r_dx_p1;
                r_dy_p2 <= r_dy_p1;
            end
            if (clr_count)
                r_cnt <= '0;
            else if (w_en_p2 && (w_clamp_x || w_clamp_y))
                r_cnt <= sat_inc(r_cnt);
        end
    end

    tmu2_wrap_axis #(.TW(TW)) u_axis_x (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .i_c         (bus.tx),
        .i_m         (bus.tex_hmask),
        .i_mode      (bus.hmode),
        .i_en_p1     (w_en_p1),
        .i_en_p2     (w_en_p2),
        .o_res       (bus.tx_m),
        .o_oor       (bus.oor_x),
        .o_clamp_evt (w_clamp_x)
    );

    tmu2_wrap_axis #(.TW(TW)) u_axis_y (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .i_c         (bus.ty),
        .i_m         (bus.tex_vmask),
        .i_mode      (bus.vmode),
        .i_en_p1     (w_en_p1),
        .i_en_p2     (w_en_p2),
        .o_res       (bus.ty_m),
        .o_oor       (bus.oor_y),
        .o_clamp_evt (w_clamp_y)
    );

    assign bus.pipe_ack_o = w_ack_p1;
    assign bus.pipe_stb_o = r_vld_p2;
    assign bus.dx_f       = r_dx_p2;
    assign bus.dy_f       = r_dy_p2;
    assign busy           = r_vld_p1 | r_vld_p2;
    assign clamp_count    = r_cnt;

endmodule
